// File: rtl/show_pkg.sv
// Types and constants shared by the show sequencer and the song modules.
package show_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_PLAY   = 2'd2,
        ST_GAP    = 2'd3
    } show_state_e;

    localparam int CLK_PER_MS_DEF = 5000;
    localparam int LIGHT_W        = 8;
    localparam int MS_W           = 20;

endpackage

// File: rtl/ms_timer.sv
// Free-running millisecond prescaler plus a clearable millisecond counter.
module ms_timer
    import show_pkg::*;
#(
    parameter int CLK_PER_MS = CLK_PER_MS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    output logic            tick,
    output logic [MS_W-1:0] ms_count
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    logic [PW-1:0]   presc_q, presc_d;
    logic [MS_W-1:0] ms_q, ms_d;

    assign tick     = (presc_q == PW'(CLK_PER_MS - 1));
    assign ms_count = ms_q;

    // Clear beats a coincident tick so a fresh interval always starts at zero.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        ms_d    = ms_q;
        if (clr) begin
            ms_d = '0;
        end else if (tick) begin
            ms_d = ms_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            ms_q    <= '0;
        end else begin
            presc_q <= presc_d;
            ms_q    <= ms_d;
        end
    end

endmodule

// File: rtl/show_sequencer.sv
// Plays the attached songs in order with dark gaps between them, a per-song
// watchdog, optional looping and an abort input.
module show_sequencer
    import show_pkg::*;
#(
    parameter int NUM_SONGS  = 4,
    parameter int CLK_PER_MS = CLK_PER_MS_DEF,
    parameter int GAP_MS     = 3000,
    parameter int TIMEOUT_MS = 600000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop_en,
    input  logic [NUM_SONGS-1:0]         song_finished,
    input  logic [LIGHT_W*NUM_SONGS-1:0] song_lights,
    output logic [NUM_SONGS-1:0]         song_go,
    output logic [LIGHT_W-1:0]           lights,
    output logic [2:0]                   cur_song,
    output logic                         busy,
    output logic                         show_done,
    output logic                         timeout_err
);

    show_state_e          state_q, state_d;
    logic [2:0]           cur_q, cur_d;
    logic [NUM_SONGS-1:0] song_go_q, song_go_d;
    logic [LIGHT_W-1:0]   lights_q, lights_d;
    logic                 show_done_q, show_done_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 ms_tick;
    logic [MS_W-1:0]      ms_count;
    logic                 tmr_clr;
    logic                 fin_sel;
    logic [LIGHT_W-1:0]   light_sel;
    logic                 last_song;
    logic                 gap_done;
    logic                 wd_fire;

    ms_timer #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_ms_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .tick    (ms_tick),
        .ms_count(ms_count)
    );

    // "Reaches N" is the tick that moves the counter from N-1 to N.
    assign gap_done  = ms_tick && (ms_count == MS_W'(GAP_MS - 1));
    assign wd_fire   = ms_tick && (ms_count == MS_W'(TIMEOUT_MS - 1));
    assign last_song = (cur_q == 3'(NUM_SONGS - 1));

    always_comb begin
        fin_sel   = 1'b0;
        light_sel = '0;
        for (int k = 0; k < NUM_SONGS; k++) begin
            if (cur_q == 3'(k)) begin
                fin_sel   = song_finished[k];
                light_sel = song_lights[k*LIGHT_W +: LIGHT_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        show_done_d   = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_LAUNCH;
                    cur_d   = '0;
                end
            end
            ST_LAUNCH: state_d = ST_PLAY;
            ST_PLAY: begin
                if (fin_sel || wd_fire) begin
                    state_d       = ST_GAP;
                    timeout_err_d = wd_fire;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    if (!last_song) begin
                        state_d = ST_LAUNCH;
                        cur_d   = cur_q + 3'd1;
                    end else if (loop_en) begin
                        state_d = ST_LAUNCH;
                        cur_d   = '0;
                    end else begin
                        state_d     = ST_IDLE;
                        show_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides every other transition and suppresses its pulses.
        if (stop && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            show_done_d   = 1'b0;
            timeout_err_d = 1'b0;
        end

        song_go_d = '0;
        if (state_d == ST_LAUNCH) begin
            for (int k = 0; k < NUM_SONGS; k++) begin
                song_go_d[k] = (cur_d == 3'(k));
            end
        end

        lights_d = (state_q == ST_PLAY && !stop) ? light_sel : '0;
        tmr_clr  = (state_d != state_q) && (state_d == ST_PLAY || state_d == ST_GAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cur_q         <= '0;
            song_go_q     <= '0;
            lights_q      <= '0;
            show_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            song_go_q     <= song_go_d;
            lights_q      <= lights_d;
            show_done_q   <= show_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign song_go     = song_go_q;
    assign lights      = lights_q;
    assign cur_song    = cur_q;
    assign busy        = (state_q != ST_IDLE);
    assign show_done   = show_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_show_sequencer.sv
// Directed bench for show_sequencer: a vector table for single-cycle behaviour
// plus hand sequences for playlist, loop, watchdog and reset corner cases.
module tb_show_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [2:0]  song_finished = 3'b000;
    logic [23:0] song_lights = 24'hC33CA5;
    logic [2:0]  song_go;
    logic [7:0]  lights;
    logic [2:0]  cur_song;
    logic        busy;
    logic        show_done;
    logic        timeout_err;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_lt [3] = '{8'hA5, 8'h3C, 8'hC3};

    typedef struct {
        logic       start;
        logic       stop;
        logic [2:0] fin;
        logic [2:0] go;
        logic       busy;
        logic [2:0] cur;
        logic [7:0] lt;
        logic       done;
    } vec_t;

    vec_t vt [8];

    show_sequencer #(
        .NUM_SONGS (3),
        .CLK_PER_MS(4),
        .GAP_MS    (2),
        .TIMEOUT_MS(50)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .song_finished(song_finished),
        .song_lights  (song_lights),
        .song_go      (song_go),
        .lights       (lights),
        .cur_song     (cur_song),
        .busy         (busy),
        .show_done    (show_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        total++;
        if (val < lo || val > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, val, lo, hi);
        end else begin
            $display("ok   %s: %0d", name, val);
        end
    endtask

    // Advance until a go pulse is visible; also reports any show_done seen.
    task automatic wait_go(input int limit, output int n, output int done_seen);
        n = 0;
        done_seen = 0;
        while (song_go == 3'b000 && n < limit) begin
            step();
            n++;
            if (show_done) done_seen++;
        end
    endtask

    task automatic pulse_fin(input int s);
        song_finished[s] = 1'b1;
        step();
        song_finished = 3'b000;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int ds;
        int lt_bad;

        vt[0] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd0, 8'h00, 1'b0};
        vt[1] = '{1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 3'd0, 8'h00, 1'b0};
        vt[2] = '{1'b1, 1'b0, 3'b000, 3'b001, 1'b1, 3'd0, 8'h00, 1'b0};
        vt[3] = '{1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 3'd0, 8'h00, 1'b0};
        vt[4] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'd0, 8'hA5, 1'b0};
        vt[5] = '{1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 3'd0, 8'hA5, 1'b0};
        vt[6] = '{1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 3'd0, 8'h00, 1'b0};
        vt[7] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd0, 8'h00, 1'b0};

        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_go", 32'(song_go), 32'd0);
        check("rst_lights", 32'(lights), 32'd0);
        check("rst_cur", 32'(cur_song), 32'd0);
        check("rst_done", 32'(show_done), 32'd0);
        check("rst_tout", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            start = vt[i].start;
            stop = vt[i].stop;
            song_finished = vt[i].fin;
            step();
            check($sformatf("v%0d_go", i), 32'(song_go), 32'(vt[i].go));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].busy));
            check($sformatf("v%0d_cur", i), 32'(cur_song), 32'(vt[i].cur));
            check($sformatf("v%0d_lights", i), 32'(lights), 32'(vt[i].lt));
            check($sformatf("v%0d_done", i), 32'(show_done), 32'(vt[i].done));
        end
        start = 1'b0;
        stop = 1'b0;
        song_finished = 3'b000;

        // Full playlist without looping.
        loop_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("pl_go%0d", s), 32'(song_go), 32'(1 << s));
            check($sformatf("pl_cur%0d", s), 32'(cur_song), 32'(s));
            step();
            step();
            check($sformatf("pl_lights%0d", s), 32'(lights), 32'(exp_lt[s]));
            repeat (38) step();
            pulse_fin(s);
            step();
            n = 1;
            lt_bad = 0;
            while (song_go == 3'b000 && !show_done && n < 20) begin
                if (lights != 8'h00 || !busy) lt_bad++;
                step();
                n++;
            end
            check_range($sformatf("pl_gap%0d", s), n, 5, 8);
            check($sformatf("pl_dark%0d", s), 32'(lt_bad), 32'd0);
        end
        check("pl_done", 32'(show_done), 32'd1);
        check("pl_busy_end", 32'(busy), 32'd0);
        check("pl_go_end", 32'(song_go), 32'd0);
        step();
        check("pl_done_1cyc", 32'(show_done), 32'd0);

        // Loop back to song 0 when loop_en is high at the last gap.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            wait_go(20, n, ds);
            check($sformatf("lp_go%0d", s), 32'(song_go), 32'(1 << s));
            repeat (3) step();
            pulse_fin(s);
        end
        loop_en = 1'b1;
        wait_go(20, n, ds);
        check("lp_wrap_go", 32'(song_go), 32'b001);
        check("lp_wrap_cur", 32'(cur_song), 32'd0);
        check("lp_no_done", 32'(ds), 32'd0);
        loop_en = 1'b0;
        do_stop();

        // Watchdog on song 1, then song 2 launches.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        pulse_fin(0);
        wait_go(20, n, ds);
        check("wd_go1", 32'(song_go), 32'b010);
        n = 0;
        while (!timeout_err && n < 300) begin
            step();
            n++;
        end
        check_range("wd_delay", n, 196, 204);
        step();
        check("wd_1cyc", 32'(timeout_err), 32'd0);
        wait_go(20, n, ds);
        check("wd_go2", 32'(song_go), 32'b100);
        check("wd_cur2", 32'(cur_song), 32'd2);
        do_stop();

        // Asynchronous reset in the middle of a gap.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        pulse_fin(0);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_cur", 32'(cur_song), 32'd0);
        check("mr_go", 32'(song_go), 32'd0);
        check("mr_lights", 32'(lights), 32'd0);
        step();
        rst_n = 1'b1;
        lt_bad = 0;
        repeat (20) begin
            step();
            if (song_go != 3'b000 || busy) lt_bad++;
        end
        check("mr_no_stale", 32'(lt_bad), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("mr_restart_go", 32'(song_go), 32'b001);
        do_stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
